// File: rtl/decode_stage.sv
// Registered RV32I decode stage with a two-entry output/skid buffer, flush and fetch-fault tagging.
// Optional RV32M and SYSTEM decode are selected by parameters.

package decode_pkg;

  typedef struct packed {
    logic [32:0] inst_raw;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        rs1_pc;
    logic        rs2_imm;
    logic [3:0]  alu_op;
    logic        branch;
    logic        jump;
    logic [2:0]  loadstore;
    logic        load_zeroextend;
    logic        inst_invalid;
  } instruction_t;

endpackage

module decode_stage
  import decode_pkg::*;
#(
  parameter bit ENABLE_M      = 1'b1,
  parameter bit ENABLE_SYSTEM = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [31:0]  i_instr,
  input  logic [31:0]  i_pc,
  input  logic         i_fault,
  output logic         o_valid,
  input  logic         i_ready,
  output instruction_t o_out,
  output logic         o_fault,
  output logic         o_muldiv,
  output logic [2:0]   o_muldiv_op,
  output logic [1:0]   o_sys,
  output logic [11:0]  o_csr_addr
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    instruction_t ins;
    logic         fault;
    logic         muldiv;
    logic [2:0]   muldiv_op;
    logic [1:0]   sys;
    logic [11:0]  csr_addr;
  } slot_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  slot_t       dec;
  slot_t       out_q, skid_q;
  logic        out_valid, skid_valid;
  logic        accept;

  assign opcode = i_instr[6:0];
  assign funct3 = i_instr[14:12];
  assign funct7 = i_instr[31:25];

  assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
  assign imm_u = {i_instr[31:12], 12'b0};

  // Register fields default to their raw instruction positions; each opcode only overrides what differs.
  always_comb begin
    dec                     = '0;
    dec.ins.inst_raw        = {1'b1, i_instr};
    dec.ins.pc              = i_pc;
    dec.ins.rs1_addr        = i_instr[19:15];
    dec.ins.rs2_addr        = i_instr[24:20];
    dec.ins.rd_addr         = i_instr[11:7];
    dec.ins.rs2_imm         = (opcode != OP_ALU);
    dec.ins.load_zeroextend = funct3[2];
    dec.fault               = i_fault;
    unique case (opcode)
      OP_LOAD: begin
        dec.ins.imm       = imm_i;
        dec.ins.loadstore = {1'b0, funct3[1:0] + 2'd1};
      end
      OP_STORE: begin
        dec.ins.imm       = imm_s;
        dec.ins.rd_addr   = 5'd0;
        dec.ins.loadstore = {1'b1, funct3[1:0] + 2'd1};
      end
      OP_ALUIMM: begin
        dec.ins.imm    = imm_i;
        dec.ins.alu_op = {(funct3 == 3'b101) & i_instr[30], funct3};
      end
      OP_ALU: begin
        if (funct7 == 7'b0000001 && ENABLE_M) begin
          dec.muldiv    = 1'b1;
          dec.muldiv_op = funct3;
        end else begin
          dec.ins.alu_op       = {i_instr[30], funct3};
          dec.ins.inst_invalid = (funct7 == 7'b0000001);
        end
      end
      OP_LUI: begin
        dec.ins.imm      = imm_u;
        dec.ins.rs1_addr = 5'd0;
      end
      OP_AUIPC: begin
        dec.ins.imm    = imm_u;
        dec.ins.rs1_pc = 1'b1;
      end
      OP_JAL: begin
        dec.ins.imm    = imm_j;
        dec.ins.rs1_pc = 1'b1;
        dec.ins.jump   = 1'b1;
      end
      OP_JALR: begin
        dec.ins.imm  = imm_i;
        dec.ins.jump = 1'b1;
      end
      OP_BRANCH: begin
        dec.ins.imm     = imm_b;
        dec.ins.rs1_pc  = 1'b1;
        dec.ins.branch  = 1'b1;
        dec.ins.rd_addr = 5'd0;
      end
      OP_FENCE: begin
        dec.ins.rd_addr  = 5'd0;
        dec.ins.rs1_addr = 5'd0;
      end
      OP_SYSTEM: begin
        if (!ENABLE_SYSTEM) begin
          dec.ins.inst_invalid = 1'b1;
        end else if (funct3 != 3'b000) begin
          dec.sys         = 2'd3;
          dec.csr_addr    = i_instr[31:20];
          dec.ins.imm     = funct3[2] ? {27'b0, i_instr[19:15]} : 32'b0;
        end else if (i_instr[31:20] == 12'd0) begin
          dec.sys = 2'd1;
        end else if (i_instr[31:20] == 12'd1) begin
          dec.sys = 2'd2;
        end else begin
          dec.ins.inst_invalid = 1'b1;
        end
      end
      default: dec.ins.inst_invalid = 1'b1;
    endcase
    if (i_fault) dec.ins.inst_invalid = 1'b1;
  end

  assign accept = i_valid & ~skid_valid;

  // SKID only fills while OUT is held, and empties into OUT first whenever OUT frees up.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else if (i_flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || i_ready) begin
      if (skid_valid) begin
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= accept;
        if (accept) out_q <= dec;
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign o_ready     = ~skid_valid;
  assign o_valid     = out_valid;
  assign o_out       = out_q.ins;
  assign o_fault     = out_q.fault;
  assign o_muldiv    = out_q.muldiv;
  assign o_muldiv_op = out_q.muldiv_op;
  assign o_sys       = out_q.sys;
  assign o_csr_addr  = out_q.csr_addr;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases, then random traffic against a queue-based reference model.
// A second instance with both extensions disabled runs on the same inputs.

module tb_decode_stage;
  import decode_pkg::*;

  typedef struct packed {
    instruction_t ins;
    logic         fault;
    logic         muldiv;
    logic [2:0]   op;
    logic [1:0]   sys;
    logic [11:0]  csr;
  } exp_t;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b1;
  logic         i_flush = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_fault = 1'b0;
  logic         i_ready = 1'b0;
  logic [31:0]  i_instr = '0;
  logic [31:0]  i_pc = '0;

  logic         o_ready, o_valid, o_fault, o_muldiv;
  instruction_t o_out;
  logic [2:0]   o_muldiv_op;
  logic [1:0]   o_sys;
  logic [11:0]  o_csr_addr;

  logic         o_ready_b, o_valid_b, o_fault_b, o_muldiv_b;
  instruction_t o_out_b;
  logic [2:0]   o_muldiv_op_b;
  logic [1:0]   o_sys_b;
  logic [11:0]  o_csr_addr_b;

  int   n_assert = 0;
  int   n_fail = 0;
  exp_t q1[$];
  exp_t q0[$];
  logic [31:0] pc = 32'h100;

  decode_stage #(.ENABLE_M(1'b1), .ENABLE_SYSTEM(1'b1)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_instr(i_instr), .i_pc(i_pc), .i_fault(i_fault), .o_valid(o_valid), .i_ready(i_ready),
    .o_out(o_out), .o_fault(o_fault), .o_muldiv(o_muldiv), .o_muldiv_op(o_muldiv_op),
    .o_sys(o_sys), .o_csr_addr(o_csr_addr)
  );

  decode_stage #(.ENABLE_M(1'b0), .ENABLE_SYSTEM(1'b0)) dut_base (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready_b),
    .i_instr(i_instr), .i_pc(i_pc), .i_fault(i_fault), .o_valid(o_valid_b), .i_ready(i_ready),
    .o_out(o_out_b), .o_fault(o_fault_b), .o_muldiv(o_muldiv_b), .o_muldiv_op(o_muldiv_op_b),
    .o_sys(o_sys_b), .o_csr_addr(o_csr_addr_b)
  );

  always #5 i_clk = ~i_clk;

  // Reference decode built from the ISA immediate definitions as plain signed arithmetic.
  function automatic exp_t model(input logic [31:0] instr, input logic [31:0] ipc, input logic flt,
                                 input bit en_m, input bit en_sys);
    exp_t e;
    logic [6:0] opc;
    logic [2:0] f3;
    logic signed [31:0] imm_i, imm_s, imm_b, imm_j;
    logic [31:0] imm_u;
    bit known;
    opc   = instr[6:0];
    f3    = instr[14:12];
    imm_i = $signed(instr) >>> 20;
    imm_s = $signed(instr[31:25]) * 32 + $signed({1'b0, instr[11:7]});
    imm_b = $signed(instr[31:31]) * 4096 + $signed({1'b0, instr[7]}) * 2048
          + $signed({1'b0, instr[30:25]}) * 32 + $signed({1'b0, instr[11:8]}) * 2;
    imm_j = $signed(instr[31:31]) * 1048576 + $signed({1'b0, instr[19:12]}) * 4096
          + $signed({1'b0, instr[20]}) * 2048 + $signed({1'b0, instr[30:21]}) * 2;
    imm_u = instr & 32'hFFFF_F000;
    known = 1'b1;
    e = '0;
    e.ins.inst_raw = {1'b1, instr};
    e.ins.pc = ipc;
    e.ins.rd_addr = instr[11:7];
    e.ins.rs1_addr = instr[19:15];
    e.ins.rs2_addr = instr[24:20];
    e.ins.rs2_imm = (opc != 7'h33);
    e.ins.load_zeroextend = f3[2];
    e.fault = flt;
    case (opc)
      7'h03: begin e.ins.imm = imm_i; e.ins.loadstore = 3'((f3 % 4 + 1) % 4); end
      7'h23: begin e.ins.imm = imm_s; e.ins.rd_addr = 0; e.ins.loadstore = 3'(4 + (f3 % 4 + 1) % 4); end
      7'h13: begin e.ins.imm = imm_i; e.ins.alu_op = 4'(f3 + ((f3 == 5 && instr[30]) ? 8 : 0)); end
      7'h33: begin
        if (instr[31:25] == 7'd1 && en_m) begin
          e.muldiv = 1'b1;
          e.op = f3;
        end else begin
          e.ins.alu_op = 4'(f3 + (instr[30] ? 8 : 0));
          if (instr[31:25] == 7'd1) known = 1'b0;
        end
      end
      7'h37: begin e.ins.imm = imm_u; e.ins.rs1_addr = 0; end
      7'h17: begin e.ins.imm = imm_u; e.ins.rs1_pc = 1'b1; end
      7'h6F: begin e.ins.imm = imm_j; e.ins.rs1_pc = 1'b1; e.ins.jump = 1'b1; end
      7'h67: begin e.ins.imm = imm_i; e.ins.jump = 1'b1; end
      7'h63: begin e.ins.imm = imm_b; e.ins.rs1_pc = 1'b1; e.ins.branch = 1'b1; e.ins.rd_addr = 0; end
      7'h0F: begin e.ins.rd_addr = 0; e.ins.rs1_addr = 0; end
      7'h73: begin
        if (!en_sys) known = 1'b0;
        else if (f3 != 0) begin
          e.sys = 2'd3;
          e.csr = instr[31:20];
          e.ins.imm = f3[2] ? 32'(instr[19:15]) : 32'd0;
        end
        else if (instr[31:20] == 12'd0) e.sys = 2'd1;
        else if (instr[31:20] == 12'd1) e.sys = 2'd2;
        else known = 1'b0;
      end
      default: known = 1'b0;
    endcase
    e.ins.inst_invalid = !known || flt;
    return e;
  endfunction

  task automatic checkVal(input string tag, input logic [159:0] obs, input logic [159:0] req);
    n_assert++;
    assert (obs === req) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h required %h", tag, obs, req);
    end
  endtask

  task automatic checkOutput();
    checkVal("valid", 160'(o_valid), 160'(q1.size() != 0));
    checkVal("ready", 160'(o_ready), 160'(q1.size() < 2));
    checkVal("valid_base", 160'(o_valid_b), 160'(q0.size() != 0));
    checkVal("ready_base", 160'(o_ready_b), 160'(q0.size() < 2));
    if (q1.size() != 0) begin
      checkVal("out", 160'(o_out), 160'(q1[0].ins));
      checkVal("side", 160'({o_fault, o_muldiv, o_muldiv_op, o_sys, o_csr_addr}),
               160'({q1[0].fault, q1[0].muldiv, q1[0].op, q1[0].sys, q1[0].csr}));
    end
    if (q0.size() != 0) begin
      checkVal("out_base", 160'(o_out_b), 160'(q0[0].ins));
      checkVal("side_base", 160'({o_fault_b, o_muldiv_b, o_muldiv_op_b, o_sys_b, o_csr_addr_b}),
               160'({q0[0].fault, q0[0].muldiv, q0[0].op, q0[0].sys, q0[0].csr}));
    end
  endtask

  // One cycle: drive inputs at the falling edge, check, then advance the model at the rising edge.
  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic flt,
                               input logic rdy, input logic fl);
    bit   acc, drn;
    exp_t e1, e0;
    i_valid = v;
    i_instr = instr;
    i_pc    = pc;
    i_fault = flt;
    i_ready = rdy;
    i_flush = fl;
    checkOutput();
    acc = v && (q1.size() < 2);
    drn = (q1.size() != 0) && rdy;
    e1  = model(instr, pc, flt, 1'b1, 1'b1);
    e0  = model(instr, pc, flt, 1'b0, 1'b0);
    @(posedge i_clk);
    if (fl) begin
      q1.delete();
      q0.delete();
    end else begin
      if (drn) begin
        void'(q1.pop_front());
        void'(q0.pop_front());
      end
      if (acc) begin
        q1.push_back(e1);
        q0.push_back(e0);
        pc = pc + 4;
      end
    end
    @(negedge i_clk);
  endtask

  task automatic checkZero(input string tag);
    checkVal({tag, "_valid"}, 160'(o_valid), 160'(0));
    checkVal({tag, "_ready"}, 160'(o_ready), 160'(1));
    checkVal({tag, "_out"}, 160'(o_out), 160'(0));
    checkVal({tag, "_side"}, 160'({o_fault, o_muldiv, o_muldiv_op, o_sys, o_csr_addr}), 160'(0));
  endtask

  initial begin
    logic [31:0] instr;
    logic [6:0]  ops [11];
    ops = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};

    #1 i_rst_n = 1'b0;
    #11 checkZero("reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    applyStimulus(1, 32'hFFF10093, 0, 1, 0);
    checkVal("addi_imm", 160'(o_out.imm), 160'(32'hFFFFFFFF));
    checkVal("addi_rs1", 160'(o_out.rs1_addr), 160'(2));
    checkVal("addi_rd", 160'(o_out.rd_addr), 160'(1));
    checkVal("addi_rs2imm", 160'(o_out.rs2_imm), 160'(1));
    checkVal("addi_pc", 160'(o_out.pc), 160'(32'h100));

    applyStimulus(1, 32'h022081B3, 0, 1, 0);
    checkVal("mul_flag", 160'(o_muldiv), 160'(1));
    checkVal("mul_op", 160'(o_muldiv_op), 160'(0));
    checkVal("mul_invalid", 160'(o_out.inst_invalid), 160'(0));
    checkVal("mul_invalid_base", 160'(o_out_b.inst_invalid), 160'(1));

    applyStimulus(1, 32'hFE000EE3, 0, 1, 0);
    checkVal("beq_branch", 160'(o_out.branch), 160'(1));
    checkVal("beq_imm", 160'(o_out.imm), 160'(32'hFFFFFFFC));
    checkVal("beq_rd", 160'(o_out.rd_addr), 160'(0));
    checkVal("beq_rs1pc", 160'(o_out.rs1_pc), 160'(1));

    applyStimulus(1, 32'h00000073, 0, 1, 0);
    checkVal("ecall_sys", 160'(o_sys), 160'(1));
    checkVal("ecall_invalid_base", 160'(o_out_b.inst_invalid), 160'(1));

    applyStimulus(1, 32'h300312F3, 0, 1, 0);
    checkVal("csr_sys", 160'(o_sys), 160'(3));
    checkVal("csr_addr", 160'(o_csr_addr), 160'(12'h300));
    checkVal("csr_rd", 160'(o_out.rd_addr), 160'(5));
    checkVal("csr_rs1", 160'(o_out.rs1_addr), 160'(6));

    // Backpressure: two held cycles fill OUT and SKID, then the stream resumes in order.
    applyStimulus(0, 32'h0, 0, 1, 0);
    applyStimulus(1, 32'h00100113, 0, 1, 0);
    applyStimulus(1, 32'h00200193, 0, 0, 0);
    applyStimulus(1, 32'h00300213, 0, 0, 0);
    checkVal("bp_ready_low", 160'(o_ready), 160'(0));
    applyStimulus(1, 32'h00300213, 0, 1, 0);
    applyStimulus(1, 32'h00300213, 0, 1, 0);
    applyStimulus(1, 32'h00400293, 0, 1, 0);
    applyStimulus(0, 32'h0, 0, 1, 0);

    // Flush with both slots occupied and a new instruction offered.
    applyStimulus(0, 32'h0, 0, 1, 0);
    applyStimulus(1, 32'h00500313, 0, 0, 0);
    applyStimulus(1, 32'h00600393, 0, 0, 0);
    applyStimulus(1, 32'h00700413, 0, 0, 1);
    checkVal("flush_valid", 160'(o_valid), 160'(0));
    checkVal("flush_ready", 160'(o_ready), 160'(1));
    applyStimulus(0, 32'h0, 0, 1, 0);

    applyStimulus(1, 32'hFFF10093, 1, 1, 0);
    checkVal("fault_flag", 160'(o_fault), 160'(1));
    checkVal("fault_invalid", 160'(o_out.inst_invalid), 160'(1));

    // Asynchronous reset in the middle of a held stream.
    applyStimulus(1, 32'h00800493, 0, 0, 0);
    applyStimulus(1, 32'h00900513, 0, 0, 0);
    i_valid = 1'b0;
    #2 i_rst_n = 1'b0;
    #1 checkZero("async_reset");
    q1.delete();
    q0.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    applyStimulus(0, 32'h0, 0, 1, 0);

    for (int i = 0; i < 400; i++) begin
      int pick;
      pick  = $urandom_range(0, 11);
      instr = $urandom;
      if (pick < 11) begin
        instr[6:0] = ops[pick];
        if (ops[pick] == 7'h33 && $urandom_range(0, 1) == 1)
          instr[31:25] = ($urandom_range(0, 1) == 1) ? 7'b0000001 : 7'b0100000;
        if (ops[pick] == 7'h73) begin
          if ($urandom_range(0, 1) == 1) instr[14:12] = 3'b000;
          case ($urandom_range(0, 2))
            0: instr[31:20] = 12'd0;
            1: instr[31:20] = 12'd1;
            default: ;
          endcase
        end
      end
      applyStimulus(1'($urandom_range(0, 3) != 0), instr, 1'($urandom_range(0, 15) == 0),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0));
    end
    applyStimulus(0, 32'h0, 0, 1, 0);
    applyStimulus(0, 32'h0, 0, 1, 0);
    applyStimulus(0, 32'h0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
